// File: rtl/alu_mc_if.sv
// Execute-stage ALU bus: operation request side and result side.
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid && ready are both high; valid-side data must be held stable while
// valid is high and ready is low, and ready may depend combinationally on
// the state of the receiver only.
interface alu_mc_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] arg1;
  logic [WIDTH-1:0] arg2;
  logic [4:0]       alu_op;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal_op;

  // Pipeline side driving operations in and draining results.
  modport master (
    output in_valid, arg1, arg2, alu_op, shamt, out_ready,
    input  in_ready, out_valid, result, zero, illegal_op
  );

  // ALU side.
  modport slave (
    input  in_valid, arg1, arg2, alu_op, shamt, out_ready,
    output in_ready, out_valid, result, zero, illegal_op
  );
endinterface

// File: rtl/alu_mc.sv
// Multicycle ALU: single-cycle integer ops with a registered output, plus
// iterative shift-add multiply and restoring unsigned divide/remainder that
// take WIDTH iterations and one write-back cycle. State is exposed on
// dbg_state_o for checkers.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       rst,
  alu_mc_if.slave    bus,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_WB   = 2'd3
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_NOR  = 5'b00100;
  localparam logic [4:0] OP_SLL  = 5'b00101;
  localparam logic [4:0] OP_SRL  = 5'b00110;
  localparam logic [4:0] OP_SRA  = 5'b00111;
  localparam logic [4:0] OP_SLT  = 5'b01000;
  localparam logic [4:0] OP_SLTU = 5'b01001;
  localparam logic [4:0] OP_XOR  = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01011;
  localparam logic [4:0] OP_DIVU = 5'b01100;
  localparam logic [4:0] OP_REMU = 5'b01101;

  localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  // mul: x = multiplicand (shifts left), y = multiplier (shifts right),
  //      acc = running product.
  // div: x = divisor, y = dividend shifting out / quotient shifting in,
  //      acc = partial remainder.
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             quo_sel_q, quo_sel_d;  // write back y (quotient) instead of acc
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  logic             in_ready;
  logic             accept;
  logic             load;
  logic [WIDTH-1:0] sc_res;
  logic             sc_illegal;
  logic             is_multi;
  logic [WIDTH:0]   trial;

  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // Single-cycle result decode; undefined opcodes yield 0 and flag illegal.
  always_comb begin
    sc_res     = '0;
    sc_illegal = 1'b0;
    is_multi   = 1'b0;
    case (bus.alu_op)
      OP_ADD:  sc_res = bus.arg1 + bus.arg2;
      OP_SUB:  sc_res = bus.arg1 - bus.arg2;
      OP_AND:  sc_res = bus.arg1 & bus.arg2;
      OP_OR:   sc_res = bus.arg1 | bus.arg2;
      OP_NOR:  sc_res = ~(bus.arg1 | bus.arg2);
      OP_SLL:  sc_res = bus.arg2 << bus.shamt;
      OP_SRL:  sc_res = bus.arg2 >> bus.shamt;
      OP_SRA:  sc_res = WIDTH'($signed(bus.arg2) >>> bus.shamt);
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.arg1) < $signed(bus.arg2))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (bus.arg1 < bus.arg2)};
      OP_XOR:  sc_res = bus.arg1 ^ bus.arg2;
      OP_MUL, OP_DIVU, OP_REMU: is_multi = 1'b1;
      default: sc_illegal = 1'b1;
    endcase
  end

  // Restoring-division trial subtract; a zero divisor always "succeeds",
  // which naturally gives an all-ones quotient and remainder = dividend.
  assign trial = {acc_q, y_q[WIDTH-1]} - {1'b0, x_q};

  // Next-state, iteration datapath and output-register control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    acc_d       = acc_q;
    quo_sel_d   = quo_sel_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    load        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_multi) begin
            cnt_d     = '0;
            acc_d     = '0;
            quo_sel_d = (bus.alu_op == OP_DIVU);
            if (bus.alu_op == OP_MUL) begin
              x_d     = bus.arg1;
              y_d     = bus.arg2;
              state_d = S_MUL;
            end else begin
              x_d     = bus.arg2;
              y_d     = bus.arg1;
              state_d = S_DIV;
            end
          end else begin
            load      = 1'b1;
            result_d  = sc_res;
            zero_d    = (sc_res == '0);
            illegal_d = sc_illegal;
          end
        end
      end
      S_MUL: begin
        acc_d = acc_q + (y_q[0] ? x_q : '0);
        x_d   = x_q << 1;
        y_d   = y_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) state_d = S_WB;
      end
      S_DIV: begin
        if (!trial[WIDTH]) begin
          acc_d = trial[WIDTH-1:0];
          y_d   = {y_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {acc_q[WIDTH-2:0], y_q[WIDTH-1]};
          y_d   = {y_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) state_d = S_WB;
      end
      S_WB: begin
        load      = 1'b1;
        result_d  = quo_sel_q ? y_q : acc_q;
        zero_d    = ((quo_sel_q ? y_q : acc_q) == '0);
        illegal_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (load)               out_valid_d = 1'b1;
    else if (bus.out_ready) out_valid_d = 1'b0;
    else                    out_valid_d = out_valid_q;
  end

  // State and datapath registers; reset aborts any iteration in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      acc_q       <= '0;
      quo_sel_q   <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      acc_q       <= acc_d;
      quo_sel_q   <= quo_sel_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.result     = result_q;
  assign bus.zero       = zero_q;
  assign bus.illegal_op = illegal_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WIDTH=32): directed cases plus randomized ops under
// random backpressure, checked against an arithmetic reference model.
module tb_alu_mc;
  localparam int W  = 32;
  localparam int SW = 5;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [W+1:0] exp_q[$];   // {illegal, zero, result}
  bit rand_bp = 1'b0;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W+1:0] ref_model(input logic [4:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [SW-1:0] sh);
    logic [W-1:0] r;
    logic         ill;
    r   = '0;
    ill = 1'b0;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a & b;
      5'd3:  r = a | b;
      5'd4:  r = ~(a | b);
      5'd5:  r = b << sh;
      5'd6:  r = b >> sh;
      5'd7:  r = $signed(b) >>> sh;
      5'd8:  r = ($signed(a) < $signed(b)) ? 1 : 0;
      5'd9:  r = (a < b) ? 1 : 0;
      5'd10: r = a ^ b;
      5'd11: r = a * b;
      5'd12: r = (b == 0) ? '1 : a / b;
      5'd13: r = (b == 0) ? a : a % b;
      default: ill = 1'b1;
    endcase
    return {ill, (r == '0), r};
  endfunction

  // ---------------- driver ----------------
  // Called shortly after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [SW-1:0] sh, output int waited);
    waited = 0;
    bus.alu_op = op; bus.arg1 = a; bus.arg2 = b; bus.shamt = sh;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      check("accept_timeout", bus.in_ready, 1);
      @(posedge clk);
    end else begin
      @(posedge clk);
      exp_q.push_back(ref_model(op, a, b, sh));
    end
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Multicycle op in isolation: busy-cycle count, latency and value.
  task automatic mc_directed(input string tag, input logic [4:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [W-1:0] exp);
    int w;
    int busy;
    send(op, a, b, '0, w);
    busy = 0;
    @(negedge clk);
    while (!bus.in_ready && busy < 100) begin
      busy++;
      @(negedge clk);
    end
    check({tag, "_busy"}, busy, W + 1);
    check({tag, "_valid"}, bus.out_valid, 1);
    check(tag, bus.result, exp);
    @(posedge clk); #1;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin : monitor
    logic [W+1:0] e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("out_without_expect", bus.out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_result", bus.result, e[W-1:0]);
        check("sb_zero", bus.zero, e[W]);
        check("sb_illegal", bus.illegal_op, e[W+1]);
      end
    end
  end

  // Random consumer backpressure during the random phase.
  initial begin : bp_drv
    forever begin
      @(posedge clk); #1;
      if (rand_bp) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int w;
    int stale;
    int n;
    logic [4:0]    op;
    logic [W-1:0]  a, b;
    logic [SW-1:0] sh;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.arg1 = '0; bus.arg2 = '0; bus.alu_op = '0; bus.shamt = '0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_zero", bus.zero, 0);
    check("rst_illegal", bus.illegal_op, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_state", dbg_state, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // single-cycle latency
    send(5'b00000, 32'd5, 32'd7, '0, w);
    @(negedge clk);
    check("add_valid", bus.out_valid, 1);
    check("add_result", bus.result, 32'd12);
    check("add_zero", bus.zero, 0);
    @(posedge clk); #1;

    // back-to-back, one per cycle
    send(5'b00001, 32'd9, 32'd9, '0, w);                 check("b2b_sub_wait", w, 0);
    send(5'b00111, 32'd0, 32'h8000_0000, 5'd4, w);       check("b2b_sra_wait", w, 0);
    send(5'b01000, 32'hFFFF_FFFF, 32'd1, '0, w);         check("b2b_slt_wait", w, 0);
    send(5'b01001, 32'hFFFF_FFFF, 32'd1, '0, w);         check("b2b_sltu_wait", w, 0);
    @(negedge clk);
    check("sltu_result", bus.result, 0);
    check("sltu_zero", bus.zero, 1);
    @(posedge clk); #1;

    // multicycle
    mc_directed("mul", 5'b01011, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F);
    mc_directed("divu", 5'b01100, 32'd100, 32'd7, 32'd14);
    mc_directed("remu", 5'b01101, 32'd100, 32'd7, 32'd2);
    mc_directed("divu0", 5'b01100, 32'd5, 32'd0, 32'hFFFF_FFFF);
    mc_directed("remu0", 5'b01101, 32'd5, 32'd0, 32'd5);

    // backpressure
    bus.out_ready = 1'b0;
    send(5'b00000, 32'h1234, 32'h1111, '0, w);
    repeat (10) begin
      @(negedge clk);
      check("bp_result", bus.result, 32'h2345);
      check("bp_in_ready", bus.in_ready, 0);
    end
    bus.alu_op = 5'b01010; bus.arg1 = 32'hF0F0; bus.arg2 = 32'h0FF0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    check("bp_queued_hold", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", bus.in_ready, 1);
    @(posedge clk);
    exp_q.push_back(ref_model(5'b01010, 32'hF0F0, 32'h0FF0, '0));
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_valid", bus.out_valid, 1);
    check("bp_next_result", bus.result, 32'hFF00);
    @(posedge clk); #1;

    // illegal opcode
    send(5'b11111, 32'd3, 32'd4, '0, w);
    @(negedge clk);
    check("ill_flag", bus.illegal_op, 1);
    check("ill_result", bus.result, 0);
    check("ill_zero", bus.zero, 1);
    @(posedge clk); #1;
    send(5'b00000, 32'd1, 32'd2, '0, w);
    @(negedge clk);
    check("ill_clear", bus.illegal_op, 0);
    check("ill_next_result", bus.result, 32'd3);
    @(posedge clk); #1;

    // reset mid-divide
    send(5'b01100, 32'd1000, 32'd3, '0, w);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_result", bus.result, 0);
    check("mid_rst_zero", bus.zero, 0);
    check("mid_rst_illegal", bus.illegal_op, 0);
    check("mid_rst_ready", bus.in_ready, 1);
    check("mid_rst_state", dbg_state, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    stale = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    check("stale_valid", stale, 0);
    @(posedge clk); #1;
    send(5'b00000, 32'd20, 32'd22, '0, w);
    @(negedge clk);
    check("post_rst_valid", bus.out_valid, 1);
    check("post_rst_result", bus.result, 32'd42);
    @(posedge clk); #1;

    // randomized ops with random backpressure
    rand_bp = 1'b1;
    repeat (150) begin
      if ($urandom_range(0, 15) == 0) op = 5'($urandom_range(14, 31));
      else                            op = 5'($urandom_range(0, 13));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = 32'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      sh = 5'($urandom_range(0, 31));
      send(op, a, b, sh, w);
    end
    @(posedge clk); #1;
    rand_bp = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
